// File: rtl/complex_nr_acc_if.sv
// rtl/complex_nr_acc_if.sv - product-in / sum-out handshake bundle for complex_nr_acc
//
// Purpose: groups the two valid/ready channels of the complex accumulator.
//   res_*  : complex product stream from the multiplier (producer -> accumulator)
//   acc_*  : finished complex sum stream (accumulator -> consumer)
// Modports:
//   master : the environment side (drives products, accepts sums)
//   slave  : the accumulator side
interface complex_nr_acc_if #(
  parameter int RES_WIDTH = 17,
  parameter int ACC_WIDTH = 19
);
  logic                        res_val;
  logic                        res_ready;
  logic signed [RES_WIDTH-1:0] res_re;
  logic signed [RES_WIDTH-1:0] res_im;
  logic                        acc_val;
  logic                        acc_ready;
  logic signed [ACC_WIDTH-1:0] acc_re;
  logic signed [ACC_WIDTH-1:0] acc_im;
  logic                        acc_ovf;

  modport master (
    output res_val, res_re, res_im, acc_ready,
    input  res_ready, acc_val, acc_re, acc_im, acc_ovf
  );

  modport slave (
    input  res_val, res_re, res_im, acc_ready,
    output res_ready, acc_val, acc_re, acc_im, acc_ovf
  );
endinterface

// File: rtl/complex_nr_acc.sv
// rtl/complex_nr_acc.sv - complex dot-product accumulator behind the complex multiplier
//
// Purpose: sums ACC_LEN consecutive complex products, then presents the sum
//   over a valid/ready handshake and clears for the next sum.
// Ports:
//   clk_i    : clock, rising edge
//   sw_rst_i : synchronous active-high reset, priority over all handshakes
//   bus      : complex_nr_acc_if.slave
//              res_val/res_ready/res_re/res_im  product input channel
//              acc_val/acc_ready/acc_re/acc_im  sum output channel
//              acc_ovf                          sticky saturation flag of the sum
// Optional feature macro: COMPLEX_ACC_SAT_EN
//   defined   : component adds saturate, stay saturated until cleared, acc_ovf sticky
//   undefined : component adds wrap modulo 2^ACC_WIDTH, acc_ovf tied low
module complex_nr_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 2 * DATA_WIDTH + 1,
  parameter int ACC_LEN    = 4,
  parameter int ACC_WIDTH  = RES_WIDTH + $clog2(ACC_LEN)
) (
  input  logic            clk_i,
  input  logic            sw_rst_i,
  complex_nr_acc_if.slave bus
);

  // ACC_LEN=1 still needs a 1-bit counter so the vector is legal.
  localparam int              CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  typedef enum logic {
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_WIDTH-1:0] acc_im_q, acc_im_d;
  logic signed [ACC_WIDTH-1:0] ext_re, ext_im;
  logic                        res_ready_o;
  logic                        acc_val_o;

  assign ext_re = ACC_WIDTH'($signed(bus.res_re));
  assign ext_im = ACC_WIDTH'($signed(bus.res_im));

`ifdef COMPLEX_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic              sat_re_q, sat_re_d;
  logic              sat_im_q, sat_im_d;
  logic [ACC_WIDTH:0] add_re, add_im;

  // Returns {saturated, result}; one guard bit exposes signed overflow.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      sat_add = {1'b1, (s[ACC_WIDTH] ? SAT_MIN : SAT_MAX)};
    end else begin
      sat_add = {1'b0, s[ACC_WIDTH-1:0]};
    end
  endfunction

  assign add_re = sat_add(acc_re_q, ext_re);
  assign add_im = sat_add(acc_im_q, ext_im);
`else
  logic signed [ACC_WIDTH-1:0] add_re, add_im;

  assign add_re = acc_re_q + ext_re;
  assign add_im = acc_im_q + ext_im;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
`ifdef COMPLEX_ACC_SAT_EN
    sat_re_d    = sat_re_q;
    sat_im_d    = sat_im_q;
`endif
    res_ready_o = 1'b0;
    acc_val_o   = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        res_ready_o = 1'b1;
        if (bus.res_val) begin
`ifdef COMPLEX_ACC_SAT_EN
          // A saturated component is frozen until the sum is cleared.
          if (!sat_re_q) begin
            acc_re_d = add_re[ACC_WIDTH-1:0];
            sat_re_d = add_re[ACC_WIDTH];
          end
          if (!sat_im_q) begin
            acc_im_d = add_im[ACC_WIDTH-1:0];
            sat_im_d = add_im[ACC_WIDTH];
          end
`else
          acc_re_d = add_re;
          acc_im_d = add_im;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_OUTPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_OUTPUT: begin
        acc_val_o = 1'b1;
        if (bus.acc_ready) begin
          state_d  = ST_ACCUM;
          acc_re_d = '0;
          acc_im_d = '0;
`ifdef COMPLEX_ACC_SAT_EN
          sat_re_d = 1'b0;
          sat_im_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sw_rst_i) begin
      state_q  <= ST_ACCUM;
      cnt_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
`ifdef COMPLEX_ACC_SAT_EN
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
`ifdef COMPLEX_ACC_SAT_EN
      sat_re_q <= sat_re_d;
      sat_im_q <= sat_im_d;
`endif
    end
  end

  assign bus.res_ready = res_ready_o;
  assign bus.acc_val   = acc_val_o;
  assign bus.acc_re    = acc_re_q;
  assign bus.acc_im    = acc_im_q;
`ifdef COMPLEX_ACC_SAT_EN
  assign bus.acc_ovf   = sat_re_q | sat_im_q;
`else
  assign bus.acc_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_complex_nr_acc.sv
// tb/tb_complex_nr_acc.sv - self-checking bench for complex_nr_acc
module tb_complex_nr_acc;

  localparam int ACC_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  complex_nr_acc_if #(.RES_WIDTH(17), .ACC_WIDTH(19)) m_if ();
  complex_nr_acc_if #(.RES_WIDTH(17), .ACC_WIDTH(18)) o_if ();

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_LEN(ACC_LEN)) dut_main (
    .clk_i   (clk),
    .sw_rst_i(rst),
    .bus     (m_if)
  );

  complex_nr_acc #(.DATA_WIDTH(8), .ACC_LEN(ACC_LEN), .ACC_WIDTH(18)) dut_ovf (
    .clk_i   (clk),
    .sw_rst_i(rst),
    .bus     (o_if)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model of the main instance: products collected in a list,
  // a finished sum is the plain integer sum of ACC_LEN of them.
  bit     mod_on = 1'b0;
  bit     pend = 1'b0;
  longint q_re[$];
  longint q_im[$];
  longint s_re = 0;
  longint s_im = 0;

  always @(posedge clk) begin
    if (rst) begin
      mod_on = 1'b1;
      pend   = 1'b0;
      q_re.delete();
      q_im.delete();
    end else if (mod_on) begin
      if (pend) begin
        if (m_if.acc_ready) pend = 1'b0;
      end else if (m_if.res_val) begin
        q_re.push_back(longint'($signed(m_if.res_re)));
        q_im.push_back(longint'($signed(m_if.res_im)));
        if (q_re.size() == ACC_LEN) begin
          s_re = 0;
          s_im = 0;
          foreach (q_re[k]) begin
            s_re += q_re[k];
            s_im += q_im[k];
          end
          pend = 1'b1;
          q_re.delete();
          q_im.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mod_on) begin
      check("cmp_res_ready", longint'(m_if.res_ready), longint'(!pend));
      check("cmp_acc_val", longint'(m_if.acc_val), longint'(pend));
      if (pend) begin
        check("cmp_acc_re", longint'($signed(m_if.acc_re)), s_re);
        check("cmp_acc_im", longint'($signed(m_if.acc_im)), s_im);
        check("cmp_acc_ovf", longint'(m_if.acc_ovf), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input bit ovf_dut, input int re, input int im);
    bit done = 1'b0;
    if (ovf_dut) begin
      o_if.res_val = 1'b1; o_if.res_re = 17'(re); o_if.res_im = 17'(im);
    end else begin
      m_if.res_val = 1'b1; m_if.res_re = 17'(re); m_if.res_im = 17'(im);
    end
    for (int i = 0; i < 50 && !done; i++) begin
      done = ovf_dut ? o_if.res_ready : m_if.res_ready;
      step();
    end
    if (!done) check("push_timeout", 0, 1);
    if (ovf_dut) o_if.res_val = 1'b0;
    else m_if.res_val = 1'b0;
  endtask

  task automatic take(input string name, input bit ovf_dut, input longint ere,
                      input longint eim, input longint eovf);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      seen = ovf_dut ? o_if.acc_val : m_if.acc_val;
      if (!seen) step();
    end
    check({name, "_valid"}, longint'(seen), 1);
    if (ovf_dut) begin
      check({name, "_re"}, longint'($signed(o_if.acc_re)), ere);
      check({name, "_im"}, longint'($signed(o_if.acc_im)), eim);
      check({name, "_ovf"}, longint'(o_if.acc_ovf), eovf);
      o_if.acc_ready = 1'b1; step(); o_if.acc_ready = 1'b0;
    end else begin
      check({name, "_re"}, longint'($signed(m_if.acc_re)), ere);
      check({name, "_im"}, longint'($signed(m_if.acc_im)), eim);
      check({name, "_ovf"}, longint'(m_if.acc_ovf), eovf);
      m_if.acc_ready = 1'b1; step(); m_if.acc_ready = 1'b0;
    end
  endtask

  initial begin
    m_if.res_val = 1'b0; m_if.res_re = '0; m_if.res_im = '0; m_if.acc_ready = 1'b0;
    o_if.res_val = 1'b0; o_if.res_re = '0; o_if.res_im = '0; o_if.acc_ready = 1'b0;

    rst = 1'b1; step(); step(); rst = 1'b0;
    check("rst_res_ready", longint'(m_if.res_ready), 1);
    check("rst_acc_val", longint'(m_if.acc_val), 0);
    check("rst_acc_re", longint'($signed(m_if.acc_re)), 0);
    check("rst_acc_im", longint'($signed(m_if.acc_im)), 0);
    check("rst_acc_ovf", longint'(m_if.acc_ovf), 0);

    // Nominal: (2+3i)(4+2i) = 2+16i, four times back to back.
    for (int i = 0; i < 4; i++) push(1'b0, 2, 16);
    check("nom_latency_val", longint'(m_if.acc_val), 1);
    check("nom_ready_low", longint'(m_if.res_ready), 0);
    take("nom", 1'b0, 8, 64, 0);

    // Signed mix.
    push(1'b0, -5, 7); push(1'b0, 3, -9); push(1'b0, -1, -1); push(1'b0, 10, 0);
    take("mix", 1'b0, 7, -3, 0);

    // Backpressure with a pending product held on the input.
    for (int i = 0; i < 4; i++) push(1'b0, 3, -2);
    m_if.res_val = 1'b1; m_if.res_re = 17'(9); m_if.res_im = 17'(9);
    for (int i = 0; i < 10; i++) begin
      check("bp_val", longint'(m_if.acc_val), 1);
      check("bp_ready", longint'(m_if.res_ready), 0);
      check("bp_re", longint'($signed(m_if.acc_re)), 12);
      check("bp_im", longint'($signed(m_if.acc_im)), -8);
      step();
    end
    m_if.acc_ready = 1'b1; step(); m_if.acc_ready = 1'b0;
    check("bp_cleared_re", longint'($signed(m_if.acc_re)), 0);
    for (int i = 0; i < 4; i++) push(1'b0, 9, 9);
    take("bp_next", 1'b0, 36, 36, 0);

    // Gapped input.
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1, -1);
      step();
    end
    take("gap", 1'b0, 4, -4, 0);

    // Reset mid-accumulation discards the partial sum.
    push(1'b0, 100, 100); push(1'b0, 100, 100);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 1, 1);
    take("rst_mid", 1'b0, 4, 4, 0);

    // Reset during OUTPUT drops acc_val.
    for (int i = 0; i < 4; i++) push(1'b0, 5, 5);
    check("rst_out_val_before", longint'(m_if.acc_val), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_out_val_after", longint'(m_if.acc_val), 0);
    check("rst_out_ready_after", longint'(m_if.res_ready), 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (!(m_if.res_val && pend)) begin
        m_if.res_val = ($urandom_range(0, 3) != 0);
        m_if.res_re  = 17'($urandom);
        m_if.res_im  = 17'($urandom);
      end
      m_if.acc_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    m_if.res_val = 1'b0; m_if.acc_ready = 1'b1;
    step(); step();
    m_if.acc_ready = 1'b0;

    // Overflow at ACC_WIDTH=18.
    for (int i = 0; i < 4; i++) push(1'b1, 65535, -65536);
`ifdef COMPLEX_ACC_SAT_EN
    take("ovf", 1'b1, 131071, -131072, 1);
`else
    take("ovf", 1'b1, -4, 0, 0);
`endif
    check("ovf_cleared", longint'(o_if.acc_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
